seg_scan_controller: RTL and testbench
======================================

Name: seg_scan_controller

Overview:
- Time-multiplexes one BCD-to-7-segment common-cathode decoder across DIGITS digits, driving the decoder's IN, LAMP_TEST and RBI inputs plus one-hot digit enables.
- Double-buffers the displayed value and performs leading-zero suppression through the decoder's ripple-blank input.
- Inserts a guard interval between digits to prevent ghosting.
- Sits between the system datapath and the display decoder.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8)
PRESCALE, 50000, clock cycles per digit slot; must be > GUARD
GUARD, 2, cycles at the start of each slot with all digit enables off (0 allowed)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous active-high reset
LOAD  input  1  one-cycle strobe: capture VALUE into pending buffer
VALUE  input  4*DIGITS  packed BCD, nibble DIGITS-1 = most significant digit
LAMP_TEST  input  1  lamp-test request
BLANK_EN  input  1  enable leading-zero suppression
BCD_OUT  output  4  to decoder IN
LT_OUT  output  1  to decoder LAMP_TEST
RBI_OUT  output  1  to decoder RBI (1 = blank if digit is 0)
DIG_EN  output  DIGITS  one-hot active-high digit enable
FRAME_DONE  output  1  one-cycle pulse on last cycle of each frame
ERR  output  1  sticky: a loaded nibble was >9

Behaviour:
- Reset values (cycle after RST high): DIG_EN=0, BCD_OUT=0, LT_OUT=0, RBI_OUT=0, FRAME_DONE=0, ERR=0, pending=0, active=0, slot counter=0, digit index=DIGITS-1. RST mid-slot aborts the slot immediately. After RST falls, scanning restarts at the MSD, slot cycle 0.
- Slot counter runs 0..PRESCALE-1 and wraps.
- Digit index decrements DIGITS-1 to 0 on each wrap, then reloads DIGITS-1. Frame length = DIGITS*PRESCALE cycles.
- States per slot:
  - GUARD (slot cycles 0..GUARD-1): DIG_EN=0.
  - ON (slot cycles GUARD..PRESCALE-1): DIG_EN bit [index]=1, all others 0.
- BCD_OUT and RBI_OUT are registered and change only at slot cycle 0. They are stable for the whole slot. BCD_OUT = active nibble[index].
- Ripple blanking: RBI_OUT = BLANK_EN & ~LT_OUT & (index != 0) & (all active nibbles above index == 0). The least significant digit is never blanked. Any nonzero higher digit clears RBI_OUT for all lower digits.
- FRAME_DONE=1 exactly on slot cycle PRESCALE-1 of index 0.
- Buffering:
  - LOAD captures VALUE into pending on the next edge.
  - active <= pending at the FRAME_DONE cycle edge, so the first slot of the next frame uses it.
  - If LOAD coincides with FRAME_DONE, active <= VALUE directly (bypass) and pending <= VALUE.
  - A mid-frame LOAD never changes the current frame. The last LOAD before the boundary wins.
- ERR sets on any LOAD whose VALUE contains a nibble >9 and holds until RST. The value is still loaded unchanged; decoder behaviour for that nibble is the decoder's.
- LT_OUT = LAMP_TEST registered, 1-cycle latency.
  - While LT_OUT=1, RBI_OUT is forced 0 from the next slot boundary onward.
  - Scanning continues unchanged, so all digits light in turn.
- BLANK_EN is sampled at each slot boundary.
- Width rule: slot counter width = clog2(PRESCALE), index width = clog2(DIGITS). No arithmetic overflow is permitted.

Test Plan:
Use overrides DIGITS=4, PRESCALE=4, GUARD=1 in all scenarios.
1. Reset: RST high 3 cycles mid-slot → all outputs 0 and ERR cleared. After release: cycle 0 DIG_EN=0000; cycles 1-3 DIG_EN=1000; cycle 4 DIG_EN=0000; cycles 5-7 DIG_EN=0100. FRAME_DONE first at cycle 15.
2. LOAD VALUE=16'h0305, BLANK_EN=1 → next frame per slot (BCD_OUT/RBI_OUT): digit3 0/1, digit2 3/1, digit1 0/0, digit0 5/0.
3. LOAD 16'h0000, BLANK_EN=1 → RBI_OUT 1,1,1,0 for digits 3..0. With BLANK_EN=0 → RBI_OUT all 0.
4. Buffering:
   - LOAD 16'h1234 at frame cycle 6 → current frame still shows the old value; next frame shows 1,2,3,4.
   - LOAD 16'h5678 on the FRAME_DONE cycle → the immediately following frame shows 5,6,7,8.
5. LAMP_TEST=1 with value 16'h0007, BLANK_EN=1 → LT_OUT=1 one cycle later; RBI_OUT=0 for all slots; DIG_EN sequence unchanged. LAMP_TEST=0 → suppression resumes at the following slot boundary.
6. LOAD 16'h00A1 → ERR=1 next cycle and stays 1 across further valid LOADs until RST. Digit1 BCD_OUT=4'hA in the following frame.

Source files
------------

// File: rtl/seg_scan_controller.sv
// seg_scan_controller
// Time-multiplexes one BCD-to-7-segment decoder across DIGITS digits.
// The displayed value is double-buffered: LOAD fills a pending register,
// and that register is promoted to the active register on the last cycle
// of a frame. Leading zeros are suppressed through the decoder's ripple
// blanking input. Each digit slot starts with a guard interval in which
// every digit enable is off, which prevents ghosting.
module seg_scan_controller #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic                  LAMP_TEST,
  input  logic                  BLANK_EN,
  output logic [3:0]            BCD_OUT,
  output logic                  LT_OUT,
  output logic                  RBI_OUT,
  output logic [DIGITS-1:0]     DIG_EN,
  output logic                  FRAME_DONE,
  output logic                  ERR
);

  localparam int SLOT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W  = $clog2(DIGITS);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PRESCALE - 1);
  localparam logic [SLOT_W-1:0] SLOT_ON   = SLOT_W'(GUARD);
  localparam logic [IDX_W-1:0]  IDX_TOP   = IDX_W'(DIGITS - 1);

  typedef enum logic {
    PH_GUARD = 1'b0,
    PH_ON    = 1'b1
  } phase_e;

  // With no guard interval a slot is lit from its first cycle onward.
  localparam phase_e PH_RESET = (GUARD == 0) ? PH_ON : PH_GUARD;

  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  phase_e              phase_q, phase_d;
  logic [4*DIGITS-1:0] pending_q, pending_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic [3:0]          bcd_q, bcd_d;
  logic                rbi_q, rbi_d;
  logic                lt_q, lt_d;
  logic [DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                fd_q, fd_d;
  logic                err_q, err_d;

  // True when any nibble of v is not a valid BCD digit.
  function automatic logic has_bad_nibble(input logic [4*DIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // True when every nibble more significant than position idx is zero.
  function automatic logic upper_zero(input logic [4*DIGITS-1:0] v,
                                      input logic [IDX_W-1:0]    idx);
    logic z;
    z = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((i > int'(idx)) && (v[4*i +: 4] != 4'd0)) z = 1'b0;
    end
    return z;
  endfunction

  // Next-state logic. Every output is registered from the next-state values,
  // so the outputs line up with the slot counter cycle they describe.
  always_comb begin
    slot_d    = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);

    idx_d     = idx_q;
    if (slot_q == SLOT_LAST) begin
      idx_d = (idx_q == '0) ? IDX_TOP : idx_q - IDX_W'(1);
    end

    phase_d   = phase_q;
    case (phase_q)
      PH_GUARD: if (slot_d == SLOT_ON) phase_d = PH_ON;
      PH_ON:    if ((GUARD != 0) && (slot_d == '0)) phase_d = PH_GUARD;
      default:  phase_d = PH_RESET;
    endcase

    dig_en_d  = '0;
    if (phase_d == PH_ON) dig_en_d[idx_d] = 1'b1;

    fd_d      = (slot_d == SLOT_LAST) && (idx_d == '0);

    pending_d = LOAD ? VALUE : pending_q;

    // The frame's last cycle promotes the buffer; a LOAD on that same
    // cycle bypasses pending so the very next frame shows it.
    active_d  = active_q;
    if (fd_q) active_d = LOAD ? VALUE : pending_q;

    err_d     = err_q | (LOAD & has_bad_nibble(VALUE));

    lt_d      = LAMP_TEST;

    // Digit data and blanking only move at a slot boundary, so the decoder
    // input is stable for the whole slot including the guard interval.
    bcd_d     = bcd_q;
    rbi_d     = rbi_q;
    if (slot_d == '0) begin
      bcd_d = active_d[{idx_d, 2'b00} +: 4];
      rbi_d = BLANK_EN & ~lt_q & (idx_d != '0) & upper_zero(active_d, idx_d);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_q    <= '0;
      idx_q     <= IDX_TOP;
      phase_q   <= PH_RESET;
      pending_q <= '0;
      active_q  <= '0;
      bcd_q     <= '0;
      rbi_q     <= 1'b0;
      lt_q      <= 1'b0;
      dig_en_q  <= '0;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      bcd_q     <= bcd_d;
      rbi_q     <= rbi_d;
      lt_q      <= lt_d;
      dig_en_q  <= dig_en_d;
      fd_q      <= fd_d;
      err_q     <= err_d;
    end
  end

  assign BCD_OUT    = bcd_q;
  assign LT_OUT     = lt_q;
  assign RBI_OUT    = rbi_q;
  assign DIG_EN     = dig_en_q;
  assign FRAME_DONE = fd_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller with DIGITS=4, PRESCALE=4, GUARD=1.
// A cycle-count based model predicts every output each cycle; literal
// expectations at chosen cycles pin the model to hand-derived values.
module tb_seg_scan_controller;

  localparam int D = 4;
  localparam int P = 4;
  localparam int G = 1;
  localparam int FRAME = D * P;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          LOAD = 1'b0;
  logic [4*D-1:0] VALUE = '0;
  logic          LAMP_TEST = 1'b0;
  logic          BLANK_EN = 1'b1;
  logic [3:0]    BCD_OUT;
  logic          LT_OUT;
  logic          RBI_OUT;
  logic [D-1:0]  DIG_EN;
  logic          FRAME_DONE;
  logic          ERR;

  seg_scan_controller #(.DIGITS(D), .PRESCALE(P), .GUARD(G)) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .VALUE(VALUE),
    .LAMP_TEST(LAMP_TEST), .BLANK_EN(BLANK_EN),
    .BCD_OUT(BCD_OUT), .LT_OUT(LT_OUT), .RBI_OUT(RBI_OUT),
    .DIG_EN(DIG_EN), .FRAME_DONE(FRAME_DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Behavioural model: t counts cycles since the last reset edge.
  bit          mv = 1'b0;
  int          t = 0;
  int unsigned latest = 0;
  int unsigned shown = 0;
  bit          m_lt = 1'b0;
  bit          m_err = 1'b0;
  bit          m_rbi = 1'b0;
  int          m_bcd = 0;
  bit          old_lt;
  int          m_digit;

  function automatic bit any_bad(input int unsigned v);
    for (int i = 0; i < D; i++) begin
      if (((v >> (4 * i)) & 15) > 9) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      mv = 1'b1; t = 0; latest = 0; shown = 0;
      m_lt = 1'b0; m_err = 1'b0; m_rbi = 1'b0; m_bcd = 0;
    end else begin
      old_lt = m_lt;
      if ((t % FRAME) == FRAME - 1) shown = LOAD ? 32'(VALUE) : latest;
      if (LOAD) begin
        latest = 32'(VALUE);
        if (any_bad(32'(VALUE))) m_err = 1'b1;
      end
      m_lt = LAMP_TEST;
      t = t + 1;
      if ((t % P) == 0) begin
        m_digit = D - 1 - ((t / P) % D);
        m_bcd   = int'((shown >> (4 * m_digit)) & 15);
        m_rbi   = BLANK_EN && !old_lt && (m_digit != 0) &&
                  ((shown >> (4 * (m_digit + 1))) == 0);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_compare();
    int slot, dig;
    logic [31:0] exp_en;
    if (!mv) return;
    slot   = t % P;
    dig    = D - 1 - ((t / P) % D);
    exp_en = (slot >= G) ? (32'd1 << dig) : 32'd0;
    check("m_dig_en", 32'(DIG_EN), exp_en);
    check("m_frame_done", 32'(FRAME_DONE), 32'((slot == P - 1) && (dig == 0)));
    check("m_bcd", 32'(BCD_OUT), 32'(m_bcd));
    check("m_rbi", 32'(RBI_OUT), 32'(m_rbi));
    check("m_lt", 32'(LT_OUT), 32'(m_lt));
    check("m_err", 32'(ERR), 32'(m_err));
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
    model_compare();
  endtask

  task automatic run_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic load_at(input int c, input logic [4*D-1:0] v);
    run_until(c);
    LOAD = 1'b1; VALUE = v;
    step();
    LOAD = 1'b0;
  endtask

  initial begin
    // Power-up reset, then a few cycles of scanning with an invalid load.
    step(); step();
    RST = 1'b0; cyc = 0;
    load_at(4, 16'h00F0);
    check("err_pre", 32'(ERR), 32'd1);
    step();
    check("dig_pre_reset", 32'(DIG_EN), 32'b0100);
    // Reset in the middle of an ON slot.
    RST = 1'b1;
    step();
    check("rst_dig", 32'(DIG_EN), 32'd0);
    check("rst_bcd", 32'(BCD_OUT), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_fd", 32'(FRAME_DONE), 32'd0);
    check("rst_rbi", 32'(RBI_OUT), 32'd0);
    step(); step();
    RST = 1'b0; cyc = 0;

    // Scan sequence after release.
    check("c0_dig", 32'(DIG_EN), 32'b0000);
    step();        check("c1_dig", 32'(DIG_EN), 32'b1000);
    run_until(3);  check("c3_dig", 32'(DIG_EN), 32'b1000);
    step();        check("c4_dig", 32'(DIG_EN), 32'b0000);
    step();        check("c5_dig", 32'(DIG_EN), 32'b0100);
    load_at(6, 16'h0305);
    run_until(14); check("c14_fd", 32'(FRAME_DONE), 32'd0);
    step();        check("c15_fd", 32'(FRAME_DONE), 32'd1);

    // Frame 1 shows 0305 with blanking.
    run_until(17); check("f1_d3", {BCD_OUT, 3'b0, RBI_OUT}, {4'h0, 3'b0, 1'b1});
    load_at(18, 16'h0000);
    run_until(21); check("f1_d2", {BCD_OUT, 3'b0, RBI_OUT}, {4'h3, 3'b0, 1'b1});
    run_until(25); check("f1_d1", {BCD_OUT, 3'b0, RBI_OUT}, {4'h0, 3'b0, 1'b0});
    run_until(29); check("f1_d0", {BCD_OUT, 3'b0, RBI_OUT}, {4'h5, 3'b0, 1'b0});

    // Frame 2: all zero, blanking on.
    run_until(33); check("f2_rbi3", 32'(RBI_OUT), 32'd1);
    run_until(37); check("f2_rbi2", 32'(RBI_OUT), 32'd1);
    run_until(41); check("f2_rbi1", 32'(RBI_OUT), 32'd1);
    run_until(45); check("f2_rbi0", 32'(RBI_OUT), 32'd0);
    run_until(46); BLANK_EN = 1'b0;

    // Frame 3: blanking off; a mid-frame load waits for the next frame.
    run_until(49); check("f3_rbi3", 32'(RBI_OUT), 32'd0);
    run_until(53); check("f3_rbi2", 32'(RBI_OUT), 32'd0);
    load_at(54, 16'h1234);
    run_until(57); check("f3_d1_old", {BCD_OUT, 3'b0, RBI_OUT}, {4'h0, 3'b0, 1'b0});
    run_until(62); BLANK_EN = 1'b1;

    // Frame 4 shows 1234.
    run_until(65); check("f4_d3", {BCD_OUT, 3'b0, RBI_OUT}, {4'h1, 3'b0, 1'b1});
    run_until(69); check("f4_d2", {BCD_OUT, 3'b0, RBI_OUT}, {4'h2, 3'b0, 1'b0});
    run_until(73); check("f4_d1", 32'(BCD_OUT), 32'h3);
    run_until(77); check("f4_d0", 32'(BCD_OUT), 32'h4);
    run_until(79); check("c79_fd", 32'(FRAME_DONE), 32'd1);
    load_at(79, 16'h5678);

    // Frame 5 shows 5678 via the bypass path.
    run_until(81); check("f5_d3", 32'(BCD_OUT), 32'h5);
    load_at(82, 16'h0007);
    run_until(85); check("f5_d2", 32'(BCD_OUT), 32'h6);
    run_until(89); check("f5_d1", 32'(BCD_OUT), 32'h7);
    run_until(90); check("lt_before", 32'(LT_OUT), 32'd0);
    LAMP_TEST = 1'b1;
    step();        check("lt_after", 32'(LT_OUT), 32'd1);
    run_until(93); check("f5_d0", {BCD_OUT, 3'b0, RBI_OUT}, {4'h8, 3'b0, 1'b0});

    // Frame 6: lamp test suppresses blanking, scan unchanged.
    run_until(96);  check("f6_c0_dig", 32'(DIG_EN), 32'b0000);
    run_until(97);  check("f6_d3", {DIG_EN, 3'b0, RBI_OUT}, {4'b1000, 3'b0, 1'b0});
    run_until(101); check("f6_d2", {DIG_EN, 3'b0, RBI_OUT}, {4'b0100, 3'b0, 1'b0});
    run_until(105); check("f6_d1_rbi", 32'(RBI_OUT), 32'd0);
    run_until(109); check("f6_d0", {BCD_OUT, 3'b0, RBI_OUT}, {4'h7, 3'b0, 1'b0});
    run_until(110); LAMP_TEST = 1'b0;
    step();         check("lt_off", 32'(LT_OUT), 32'd0);

    // Frame 7: blanking resumes; invalid load sets ERR.
    run_until(113); check("f7_rbi3", 32'(RBI_OUT), 32'd1);
    run_until(114); check("err_before", 32'(ERR), 32'd0);
    load_at(114, 16'h00A1);
    check("err_set", 32'(ERR), 32'd1);
    run_until(117); check("f7_rbi2", 32'(RBI_OUT), 32'd1);
    run_until(121); check("f7_rbi1", 32'(RBI_OUT), 32'd1);
    run_until(125); check("f7_d0", {BCD_OUT, 3'b0, RBI_OUT}, {4'h7, 3'b0, 1'b0});

    // Frame 8 shows 00A1; ERR is sticky across a valid load.
    load_at(130, 16'h0042);
    check("err_sticky1", 32'(ERR), 32'd1);
    run_until(137); check("f8_d1", 32'(BCD_OUT), 32'hA);
    run_until(140); check("err_sticky2", 32'(ERR), 32'd1);

    // Final reset clears ERR.
    run_until(144);
    RST = 1'b1;
    step();
    check("rst2_err", 32'(ERR), 32'd0);
    check("rst2_dig", 32'(DIG_EN), 32'd0);
    check("rst2_bcd", 32'(BCD_OUT), 32'd0);
    RST = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
